// File: rtl/pc_seq_pkg.sv
// rtl/pc_seq_pkg.sv - shared types and constants for the PC sequencer
package pc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_JMP  = 2'd1,
    CAUSE_BR   = 2'd2,
    CAUSE_EXC  = 2'd3
  } cause_t;

  localparam int PC_INC = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

endpackage

// File: rtl/pc_next_mux.sv
// rtl/pc_next_mux.sv - priority select of the next PC and redirect cause
module pc_next_mux
  import pc_seq_pkg::*;
#(
  parameter int              WORD    = 32,
  parameter logic [WORD-1:0] EXC_VEC = EXC_VEC_DEF[WORD-1:0]
) (
  input  logic [WORD-1:0] pc_plus,
  input  logic            jump,
  input  logic [WORD-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  input  logic            exc,
  input  logic [WORD-1:0] pending_pc,
  input  logic            drain,
  input  logic            pending_lock,
  output logic [WORD-1:0] next_pc,
  output cause_t          cause
);

  always_comb begin
    cause = CAUSE_NONE;
    if (exc)               cause = CAUSE_EXC;
    else if (branch_taken) cause = CAUSE_BR;
    else if (jump)         cause = CAUSE_JMP;
  end

  // A latched exception target outranks any later non-exception redirect.
  always_comb begin
    next_pc = pc_plus;
    if (exc)               next_pc = EXC_VEC;
    else if (pending_lock) next_pc = pending_pc;
    else if (branch_taken) next_pc = {branch_target[WORD-1:2], 2'b00};
    else if (jump)         next_pc = {jump_target[WORD-1:2], 2'b00};
    else if (drain)        next_pc = pending_pc;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC register, fetch FSM and redirect handling
// Optional cycle trace compiled in when PC_TRACE_EN is defined.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              WORD      = 32,
  parameter logic [WORD-1:0] RESET_VEC = RESET_VEC_DEF[WORD-1:0],
  parameter logic [WORD-1:0] EXC_VEC   = EXC_VEC_DEF[WORD-1:0]
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            jump,
  input  logic [WORD-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [WORD-1:0] branch_target,
  input  logic            exc,
  input  logic            imem_ready,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  output logic [WORD-1:0] pc_curr,
  output logic            issue_valid,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [1:0]      seq_state
);

  seq_state_t      state, state_n;
  logic [WORD-1:0] pc_n;
  logic [WORD-1:0] pending_pc, pending_pc_n;
  logic            pending_exc, pending_exc_n;
  logic [WORD-1:0] mux_pc;
  cause_t          cause;
  logic            redirect;
  logic            in_drain;

  assign in_drain = (state == DRAIN);

  pc_next_mux #(
    .WORD    (WORD),
    .EXC_VEC (EXC_VEC)
  ) u_mux (
    .pc_plus       (pc_curr + WORD'(PC_INC)),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exc           (exc),
    .pending_pc    (pending_pc),
    .drain         (in_drain),
    .pending_lock  (in_drain && pending_exc),
    .next_pc       (mux_pc),
    .cause         (cause)
  );

  assign redirect = (cause != CAUSE_NONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc_curr     <= RESET_VEC;
      pending_pc  <= '0;
      pending_exc <= 1'b0;
    end else begin
      state       <= state_n;
      pc_curr     <= pc_n;
      pending_pc  <= pending_pc_n;
      pending_exc <= pending_exc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc_curr;
    pending_pc_n  = pending_pc;
    pending_exc_n = pending_exc;
    imem_req      = 1'b0;
    issue_valid   = 1'b0;
    case (state)
      IDLE: state_n = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          if (imem_ready) begin
            pc_n = mux_pc;
          end else begin
            pending_pc_n  = mux_pc;
            pending_exc_n = (cause == CAUSE_EXC);
            state_n       = DRAIN;
          end
        end else if (!stall && imem_ready) begin
          issue_valid = 1'b1;
          pc_n        = mux_pc;
        end
      end
      DRAIN: begin
        imem_req = 1'b1;
        // The abandoned word is dropped; mux_pc already reflects any same-cycle redirect.
        if (imem_ready) begin
          pc_n          = mux_pc;
          pending_exc_n = 1'b0;
          state_n       = FETCH;
        end else if (redirect) begin
          pending_pc_n  = mux_pc;
          pending_exc_n = pending_exc || (cause == CAUSE_EXC);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign flush_if_id = (state != IDLE) && redirect;
  assign flush_id_ex = (state != IDLE) && (exc || branch_taken);
  assign imem_addr   = pc_curr;
  assign seq_state   = state;

`ifdef PC_TRACE_EN
  always @(posedge clk) begin
    if (flush_if_id)
      $display("----------------------------------------");
    $display("Time: %d, PC = %h, state = %d, issue = %b", $time, pc_curr, state, issue_valid);
  end
`else
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven self-checking bench for pc_sequencer
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, jump, branch_taken, exc, imem_ready;
  logic [31:0] jump_target, branch_target;
  logic        imem_req, issue_valid, flush_if_id, flush_id_ex;
  logic [31:0] imem_addr, pc_curr;
  logic [1:0]  seq_state;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .exc           (exc),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .pc_curr       (pc_curr),
    .issue_valid   (issue_valid),
    .flush_if_id   (flush_if_id),
    .flush_id_ex   (flush_id_ex),
    .seq_state     (seq_state)
  );

  typedef struct {
    logic        stall, jump;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        exc, ready;
    logic [31:0] addr;
    logic        issue, fif, fie;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic s, input logic j, input logic [31:0] jt,
                              input logic b, input logic [31:0] bt, input logic e,
                              input logic r, input logic [31:0] a, input logic iv,
                              input logic fi, input logic fe, input logic [1:0] st);
    vec_t v;
    v.stall = s; v.jump = j; v.jt = jt; v.br = b; v.bt = bt; v.exc = e; v.ready = r;
    v.addr = a; v.issue = iv; v.fif = fi; v.fie = fe; v.st = st;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic [31:0] a, input logic iv,
                            input logic fi, input logic fe, input logic [1:0] st);
    check("imem_addr", idx, imem_addr, a);
    check("pc_curr", idx, pc_curr, a);
    check("issue_valid", idx, 32'(issue_valid), 32'(iv));
    check("flush_if_id", idx, 32'(flush_if_id), 32'(fi));
    check("flush_id_ex", idx, 32'(flush_id_ex), 32'(fe));
    check("seq_state", idx, 32'(seq_state), 32'(st));
    check("imem_req", idx, 32'(imem_req), 32'(st != 2'd0));
  endtask

  task automatic drive(input vec_t v);
    stall = v.stall; jump = v.jump; jump_target = v.jt; branch_taken = v.br;
    branch_target = v.bt; exc = v.exc; imem_ready = v.ready;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //          stall jump jt            br  bt            exc rdy addr          iss fif fie st
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0000, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0004, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0008, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_000C, 1, 0, 0, 2'd1));
    vq.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0010, 0, 0, 0, 2'd1));
    vq.push_back(mk(1, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0010, 0, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0010, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0014, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0018, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_001C, 1, 0, 0, 2'd1));
    vq.push_back(mk(1, 0, 32'h0,         1, 32'h0000_0103, 0, 1, 32'h0000_0020, 0, 1, 1, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0100, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 1, 32'h0000_0400, 0, 32'h0,         0, 0, 32'h0000_0104, 0, 1, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0104, 0, 0, 0, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0104, 0, 0, 0, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0104, 0, 0, 0, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0400, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 1, 32'h0000_0800, 0, 32'h0,         0, 0, 32'h0000_0404, 0, 1, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 0, 32'h0000_0404, 0, 1, 1, 2'd2));
    vq.push_back(mk(0, 1, 32'h0000_0C00, 0, 32'h0,         0, 0, 32'h0000_0404, 0, 1, 0, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0200, 0, 1, 32'h0000_0404, 0, 1, 1, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0180, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         1, 1, 32'h0000_0184, 0, 1, 1, 2'd1));
    vq.push_back(mk(0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 1, 32'h0000_0180, 0, 1, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'hFFFF_FFFC, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 1, 32'h0000_0000, 1, 0, 0, 2'd1));
    vq.push_back(mk(0, 1, 32'h0000_0050, 0, 32'h0,         0, 0, 32'h0000_0004, 0, 1, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         1, 32'h0000_0060, 0, 1, 32'h0000_0004, 0, 1, 1, 2'd2));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0060, 0, 0, 0, 2'd1));
    vq.push_back(mk(0, 1, 32'h0000_0070, 0, 32'h0,         0, 0, 32'h0000_0060, 0, 1, 0, 2'd1));
    vq.push_back(mk(0, 0, 32'h0,         0, 32'h0,         0, 0, 32'h0000_0060, 0, 0, 0, 2'd2));

    // Reset state, with a redirect request held to confirm flushes stay low.
    rst_n = 1'b0;
    stall = 0; jump = 1; jump_target = 32'h40; branch_taken = 0; branch_target = 0;
    exc = 0; imem_ready = 1;
    @(negedge clk);
    check_outs(-1, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    jump = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vq[i]) begin
      drive(vq[i]);
      @(negedge clk);
      check_outs(i, vq[i].addr, vq[i].issue, vq[i].fif, vq[i].fie, vq[i].st);
      @(posedge clk); #1;
    end

    // Asynchronous reset mid-DRAIN, away from any clock edge.
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0));
    #2;
    check("pre_reset_state", 100, 32'(seq_state), 32'd2);
    rst_n = 1'b0;
    #1;
    check_outs(101, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_outs(102, 32'h0, 1'b0, 1'b0, 1'b0, 2'd0);
    @(posedge clk); #1;
    imem_ready = 1'b1;
    @(negedge clk);
    check_outs(103, 32'h0, 1'b1, 1'b0, 1'b0, 2'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_outs(104, 32'h4, 1'b1, 1'b0, 1'b0, 2'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
